// File: rtl/rx_gearbox.sv
// rx_gearbox: 64b66b receive gearbox, re-frames a 32-bit word stream into 66-bit blocks emitted as two words.
// Optional sync-header legality check is built when RX_GEARBOX_HDR_CHECK_EN is defined.
module rx_gearbox #(
    parameter int SLIP_HOLDOFF = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_data,
    input  logic        i_slip,
    output logic [31:0] o_data,
    output logic [1:0]  o_header,
    output logic        o_data_valid,
    output logic        o_header_valid,
    output logic        o_frame_word,
    output logic        o_slip_busy,
    output logic        o_header_err
);

    localparam int DATA_WIDTH   = 32;
    localparam int HEADER_WIDTH = 2;
    localparam int BUF_WIDTH    = 2 * DATA_WIDTH + HEADER_WIDTH;
    localparam logic [6:0] NEED_HDR  = 7'd34;
    localparam logic [6:0] NEED_DAT  = 7'd32;
    localparam logic [6:0] WORD_BITS = 7'd32;
    localparam logic [7:0] HOLD_LOAD = 8'(SLIP_HOLDOFF);

    typedef enum logic {
        PH_HDR = 1'b0,
        PH_DAT = 1'b1
    } phase_t;

    phase_t                 r_phase;
    phase_t                 w_phase_next;
    logic [BUF_WIDTH-1:0]   r_buf;
    logic [BUF_WIDTH-1:0]   w_buf_next;
    logic [BUF_WIDTH-1:0]   w_app;
    logic [BUF_WIDTH-1:0]   w_buf_s;
    logic [6:0]             r_fill;
    logic [6:0]             w_fill_next;
    logic [6:0]             w_fill_s;
    logic [6:0]             w_need;
    logic [7:0]             r_hold;
    logic [7:0]             w_hold_next;
    logic                   w_slip_acc;
    logic                   w_extract;

    logic [31:0]            r_data;
    logic [1:0]             r_header;
    logic                   r_data_valid;
    logic                   r_header_valid;
    logic                   r_frame_word;
    logic                   r_slip_busy;
    logic [31:0]            w_data_next;
    logic [1:0]             w_header_next;
    logic                   w_data_valid_next;
    logic                   w_header_valid_next;
    logic                   w_frame_word_next;

    // Append, optional one-bit slip, then at most one word extraction per cycle.
    always_comb begin
        w_app               = r_buf | ({{(BUF_WIDTH-DATA_WIDTH){1'b0}}, i_data} << r_fill);
        w_slip_acc          = i_slip && (r_hold == 8'd0);
        w_buf_s             = w_app;
        w_fill_s            = r_fill + WORD_BITS;
        w_need              = NEED_HDR;
        w_extract           = 1'b0;
        w_buf_next          = w_buf_s;
        w_fill_next         = w_fill_s;
        w_phase_next        = r_phase;
        w_hold_next         = r_hold;
        w_data_next         = 32'd0;
        w_header_next       = 2'b00;
        w_data_valid_next   = 1'b0;
        w_header_valid_next = 1'b0;
        w_frame_word_next   = r_frame_word;

        if (w_slip_acc) begin
            w_buf_s     = w_app >> 1;
            w_fill_s    = r_fill + WORD_BITS - 7'd1;
            w_hold_next = HOLD_LOAD;
        end else if (r_hold != 8'd0) begin
            w_hold_next = r_hold - 8'd1;
        end else begin
            w_hold_next = r_hold;
        end

        case (r_phase)
            PH_HDR:  w_need = NEED_HDR;
            PH_DAT:  w_need = NEED_DAT;
            default: w_need = NEED_HDR;
        endcase

        w_extract   = (w_fill_s >= w_need);
        w_buf_next  = w_buf_s;
        w_fill_next = w_fill_s;

        if (w_extract) begin
            w_buf_next        = w_buf_s >> w_need;
            w_fill_next       = w_fill_s - w_need;
            w_data_valid_next = 1'b1;
            case (r_phase)
                PH_HDR: begin
                    w_header_next       = w_buf_s[HEADER_WIDTH-1:0];
                    w_data_next         = w_buf_s[DATA_WIDTH+HEADER_WIDTH-1:HEADER_WIDTH];
                    w_header_valid_next = 1'b1;
                    w_frame_word_next   = 1'b0;
                    w_phase_next        = PH_DAT;
                end
                PH_DAT: begin
                    w_data_next       = w_buf_s[DATA_WIDTH-1:0];
                    w_frame_word_next = 1'b1;
                    w_phase_next      = PH_HDR;
                end
                default: begin
                    w_phase_next = PH_HDR;
                end
            endcase
        end else begin
            w_phase_next = r_phase;
        end
    end

    // Phase state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_phase <= PH_HDR;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Bit buffer, fill level and slip holdoff.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_buf  <= '0;
            r_fill <= 7'd0;
            r_hold <= 8'd0;
        end else begin
            r_buf  <= w_buf_next;
            r_fill <= w_fill_next;
            r_hold <= w_hold_next;
        end
    end

    // Output registers; busy mirrors the holdoff counter as it will be next cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_data         <= 32'd0;
            r_header       <= 2'b00;
            r_data_valid   <= 1'b0;
            r_header_valid <= 1'b0;
            r_frame_word   <= 1'b0;
            r_slip_busy    <= 1'b0;
        end else begin
            r_data         <= w_data_next;
            r_header       <= w_header_next;
            r_data_valid   <= w_data_valid_next;
            r_header_valid <= w_header_valid_next;
            r_frame_word   <= w_frame_word_next;
            r_slip_busy    <= (w_hold_next != 8'd0);
        end
    end

`ifdef RX_GEARBOX_HDR_CHECK_EN
    function automatic logic hdr_illegal(input logic [1:0] hdr);
        return (hdr == 2'b00) || (hdr == 2'b11);
    endfunction

    logic r_header_err;

    // Header legality flag, registered alongside the HDR word.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_header_err <= 1'b0;
        end else begin
            r_header_err <= w_header_valid_next && hdr_illegal(w_header_next);
        end
    end

    assign o_header_err = r_header_err;
`else
    assign o_header_err = 1'b0;
`endif

    assign o_data         = r_data;
    assign o_header       = r_header;
    assign o_data_valid   = r_data_valid;
    assign o_header_valid = r_header_valid;
    assign o_frame_word   = r_frame_word;
    assign o_slip_busy    = r_slip_busy;

endmodule

// File: tb/tb_rx_gearbox.sv
// tb_rx_gearbox: directed self-checking bench for rx_gearbox; a bit-serial TX framer feeds the 32-bit input.
module tb_rx_gearbox;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_data;
    logic        i_slip;
    logic [31:0] o_data;
    logic [1:0]  o_header;
    logic        o_data_valid;
    logic        o_header_valid;
    logic        o_frame_word;
    logic        o_slip_busy;
    logic        o_header_err;

    int checks   = 0;
    int failures = 0;

`ifdef RX_GEARBOX_HDR_CHECK_EN
    localparam bit HDR_CHECK = 1'b1;
`else
    localparam bit HDR_CHECK = 1'b0;
`endif

    bit          tx_q[$];
    logic [65:0] exp_q[$];
    int          gen_mode;
    logic [1:0]  gen_hdr;
    logic [63:0] gen_data;
    int          gen_idx;
    logic [1:0]  hdr_tbl [4] = '{2'b01, 2'b00, 2'b10, 2'b11};

    rx_gearbox #(.SLIP_HOLDOFF(4)) dut (
        .i_clk          (clk),
        .i_reset_n      (i_reset_n),
        .i_data         (i_data),
        .i_slip         (i_slip),
        .o_data         (o_data),
        .o_header       (o_header),
        .o_data_valid   (o_data_valid),
        .o_header_valid (o_header_valid),
        .o_frame_word   (o_frame_word),
        .o_slip_busy    (o_slip_busy),
        .o_header_err   (o_header_err)
    );

    always #5 clk = ~clk;

    function automatic logic exp_err(input logic [1:0] h);
        return HDR_CHECK && ((h == 2'b00) || (h == 2'b11));
    endfunction

    // Serialise one frame onto the wire: header bit 0 first, then data bit 0 upward.
    task automatic push_frame(input logic [1:0] h, input logic [63:0] d);
        for (int i = 0; i < 2; i++) tx_q.push_back(h[i]);
        for (int i = 0; i < 64; i++) tx_q.push_back(d[i]);
        if (gen_mode == 1) exp_q.push_back({d, h});
    endtask

    task automatic next_word(output logic [31:0] w);
        while (tx_q.size() < 32) begin
            if (gen_mode == 0) begin
                push_frame(gen_hdr, gen_data);
            end else begin
                push_frame(hdr_tbl[gen_idx % 4], {16'hD00D, gen_idx[15:0], 16'hBEEF, ~gen_idx[15:0]});
                gen_idx++;
            end
        end
        for (int b = 0; b < 32; b++) w[b] = tx_q.pop_front();
    endtask

    task automatic drive_cycle(input logic slip);
        logic [31:0] w;
        next_word(w);
        i_data = w;
        i_slip = slip;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int mode, input logic [1:0] h, input logic [63:0] d, input int junk);
        i_reset_n = 1'b0;
        i_slip    = 1'b0;
        i_data    = 32'd0;
        tx_q.delete();
        exp_q.delete();
        gen_mode = mode;
        gen_hdr  = h;
        gen_data = d;
        gen_idx  = 0;
        for (int i = 0; i < junk; i++) tx_q.push_back(1'b1);
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    // 66 cycles after lock: every word must be the transmitted frame content, alternating HDR/DAT.
    task automatic run_locked(input string name, input logic [1:0] h, input logic [63:0] d);
        logic [38:0] obs, exp;
        bit have_last = 1'b0;
        bit last_hdr  = 1'b0;
        bit is_hdr;
        int nvalid = 0;
        for (int c = 0; c < 66; c++) begin
            drive_cycle(1'b0);
            if (o_data_valid) begin
                nvalid++;
                is_hdr = have_last ? !last_hdr : o_header_valid;
                exp = is_hdr ? {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, h, d[31:0]}
                             : {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, d[63:32]};
                obs = {o_data_valid, o_header_valid, o_frame_word, o_slip_busy, o_header_err, o_header, o_data};
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL %s locked c=%0d: got %h expected %h", name, c, obs, exp);
                end
                last_hdr  = is_hdr;
                have_last = 1'b1;
            end
        end
        checks++;
        if (nvalid !== 64) begin
            failures++;
            $display("FAIL %s valid_count: got %0d expected 64", name, nvalid);
        end
    endtask

    task automatic test_reset();
        logic [38:0] obs;
        @(negedge clk);
        obs = {o_data_valid, o_header_valid, o_frame_word, o_slip_busy, o_header_err, o_header, o_data};
        checks++;
        if (obs !== 39'd0) begin
            failures++;
            $display("FAIL reset_state: got %h expected 0", obs);
        end
    endtask

    task automatic test_aligned();
        logic [38:0] obs, exp;
        bit   exp_hdr = 1'b1;
        logic exp_fw  = 1'b0;
        do_reset(0, 2'b01, 64'hFEDC_BA98_7654_3210, 0);
        for (int k = 0; k < 100; k++) begin
            drive_cycle(1'b0);
            if ((k % 33) != 0) begin
                if (exp_hdr) begin
                    exp    = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h7654_3210};
                    exp_fw = 1'b0;
                end else begin
                    exp    = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'hFEDC_BA98};
                    exp_fw = 1'b1;
                end
                exp_hdr = !exp_hdr;
            end else begin
                exp = {1'b0, 1'b0, exp_fw, 1'b0, 1'b0, 2'b00, 32'd0};
            end
            obs = {o_data_valid, o_header_valid, o_frame_word, o_slip_busy, o_header_err, o_header, o_data};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL aligned k=%0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_misalign(input string name, input int junk, input int nslips,
                                 input logic [1:0] h, input logic [63:0] d);
        do_reset(0, h, d, junk);
        for (int c = 0; c <= (nslips - 1) * 5; c++) drive_cycle((c % 5) == 0);
        repeat (4) drive_cycle(1'b0);
        run_locked(name, h, d);
    endtask

    task automatic test_slip_busy();
        logic exp_busy;
        do_reset(0, 2'b10, 64'h0123_4567_89AB_CDEF, 2);
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b1);
            exp_busy = ((c % 5) != 4);
            checks++;
            if (o_slip_busy !== exp_busy) begin
                failures++;
                $display("FAIL slip_busy c=%0d: got %b expected %b", c, o_slip_busy, exp_busy);
            end
        end
        repeat (3) drive_cycle(1'b0);
        run_locked("slip_busy", 2'b10, 64'h0123_4567_89AB_CDEF);
    endtask

    task automatic test_reset_mid_frame();
        logic [38:0] obs, exp;
        bit found = 1'b0;
        do_reset(0, 2'b01, 64'hFEDC_BA98_7654_3210, 0);
        drive_cycle(1'b1);
        for (int k = 0; k < 8 && !found; k++) begin
            drive_cycle(1'b0);
            found = o_header_valid;
        end
        checks++;
        if (!found || o_slip_busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: got hv=%b busy=%b expected hv=1 busy=1", o_header_valid, o_slip_busy);
        end
        i_reset_n = 1'b0;
        #1;
        obs = {o_data_valid, o_header_valid, o_frame_word, o_slip_busy, o_header_err, o_header, o_data};
        checks++;
        if (obs !== 39'd0) begin
            failures++;
            $display("FAIL midreset_async: got %h expected 0", obs);
        end
        tx_q.delete();
        @(negedge clk);
        i_reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0);
            case (k)
                0:       exp = 39'd0;
                1:       exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h7654_3210};
                default: exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'hFEDC_BA98};
            endcase
            obs = {o_data_valid, o_header_valid, o_frame_word, o_slip_busy, o_header_err, o_header, o_data};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL midreset_restart k=%0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_header_check();
        logic [38:0] obs, exp;
        logic [65:0] f, cur;
        bit   exp_hdr = 1'b1;
        logic exp_fw  = 1'b0;
        cur = '0;
        do_reset(1, 2'b00, 64'd0, 0);
        for (int k = 0; k < 70; k++) begin
            drive_cycle(1'b0);
            if ((k % 33) != 0) begin
                if (exp_hdr) begin
                    f   = (exp_q.size() > 0) ? exp_q.pop_front() : 66'd0;
                    cur = f;
                    exp = {1'b1, 1'b1, 1'b0, 1'b0, exp_err(f[1:0]), f[1:0], f[33:2]};
                    exp_fw = 1'b0;
                end else begin
                    exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, cur[65:34]};
                    exp_fw = 1'b1;
                end
                exp_hdr = !exp_hdr;
            end else begin
                exp = {1'b0, 1'b0, exp_fw, 1'b0, 1'b0, 2'b00, 32'd0};
            end
            obs = {o_data_valid, o_header_valid, o_frame_word, o_slip_busy, o_header_err, o_header, o_data};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL header_check k=%0d: got %h expected %h", k, obs, exp);
            end
        end
    endtask

    initial begin
        i_reset_n = 1'b1;
        i_slip    = 1'b0;
        i_data    = 32'd0;
        #1 i_reset_n = 1'b0;
        test_reset();
        test_aligned();
        test_misalign("misalign5", 5, 5, 2'b01, 64'hFEDC_BA98_7654_3210);
        test_misalign("misalign61", 61, 61, 2'b10, 64'h1357_9BDF_0246_8ACE);
        test_slip_busy();
        test_reset_mid_frame();
        test_header_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_gearbox.md
# rx_gearbox

64b66b receive synchronous gearbox with a 32-bit interface. It takes the continuous 32-bit word stream from the transceiver RX datapath and re-frames it into 66-bit blocks, emitted over two cycles. The first cycle carries the 2-bit sync header plus data bits [31:0]; the second carries data bits [63:32]. It sits between the transceiver and the descrambler/block-lock logic, and provides a one-bit slip control for block alignment.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width; fixed, not overridable.
- `HEADER_WIDTH`, 2: sync header width; fixed.
- `SLIP_HOLDOFF`, 4: cycles after an accepted slip during which further slips are ignored; range 0..255.

Ports:
- `i_clk`, in, 1: RX clock.
- `i_reset_n`, in, 1: reset, asynchronous and active-low.
- `i_data`, in, 32: received word, every cycle; `i_data[0]` is the earliest bit on the wire.
- `i_slip`, in, 1: request to discard one bit; level-sampled each cycle.
- `o_data`, out, 32: frame data word.
- `o_header`, out, 2: sync header; `o_header[0]` is the first header bit on the wire.
- `o_data_valid`, out, 1: `o_data` holds a valid word this cycle.
- `o_header_valid`, out, 1: `o_header` is valid; high only on the lower (first) word of a frame.
- `o_frame_word`, out, 1: 0 = lower word (with header), 1 = upper word.
- `o_slip_busy`, out, 1: high while slips are ignored.
- `o_header_err`, out, 1: header is 2'b00 or 2'b11; see Configuration.

## Operation
- State:
  - 66-bit bit buffer, oldest bit at index 0.
  - 7-bit fill count.
  - Phase flag: HDR (needs 34 bits) or DAT (needs 32 bits).
  - Holdoff counter.
- Each cycle, in order:
  1. Append `i_data` at `buf[fill +: 32]`; `fill += 32`.
  2. If a slip is accepted, drop `buf[0]` (shift down one bit) and `fill -= 1`.
  3. If `fill >= need`, extract the output word, shift the buffer down by `need`, subtract `need` from fill, and toggle phase. Otherwise emit nothing and leave phase unchanged.
- HDR extraction: `o_header = buf[1:0]`, `o_data = buf[33:2]`, `o_frame_word = 0`, `o_header_valid = 1`.
- DAT extraction: `o_data = buf[31:0]`, `o_frame_word = 1`, `o_header_valid = 0`.
- Invariants: fill after extraction is ≤ 33 and fill before extraction is ≤ 65, so a 66-bit buffer never overflows. Fill is never negative after step 2.
- Steady state without slips: a repeating 33-cycle pattern of 32 valid words followed by 1 invalid cycle. This mirrors the TX gearbox sequence 0..32.
- Each accepted slip delays all later frame boundaries by one bit. After 66 net slips the alignment returns to its original position, with one extra frame-pair of invalid cycles inserted.
- Slip acceptance:
  - A slip is accepted when `i_slip = 1` and the holdoff counter is 0.
  - On acceptance the counter loads `SLIP_HOLDOFF` and decrements once per cycle to 0.
  - `o_slip_busy = (counter != 0)`.
  - Slips seen while busy are dropped, not queued.
  - With `SLIP_HOLDOFF = 0`, a slip is accepted every cycle `i_slip` is high.

## Timing
- All outputs are registered.
- An output word appears on the cycle after the cycle whose `i_data` completed it.
- From reset release:
  - Cycle 0: fill reaches 32, below the 34 needed, so no output.
  - Cycle 1: completes the first HDR word.
  - First `o_data_valid` occurs in cycle 2.
- When `o_data_valid = 0`, `o_data`, `o_header`, `o_header_valid` and `o_header_err` are 0, and `o_frame_word` holds its previous value.
- Slip latency: the one-bit shift applies to extraction in the same cycle `i_slip` is sampled, so it is visible in the next output word. `o_slip_busy` rises the cycle after acceptance.
- Reset (asynchronous, any time): all outputs go to 0, buffer and fill are cleared, phase = HDR, holdoff = 0. Any partial frame is lost.

## Configuration
- `RX_GEARBOX_HDR_CHECK_EN` defined: `o_header_err` is registered with the HDR word and is high when the header is 2'b00 or 2'b11 and `o_header_valid = 1`.
- Not defined: `o_header_err` is tied to 0; no check logic is built. The port remains present.

## Test plan
- **Aligned stream after reset:** drive the TX gearbox output for frames with header 2'b01 and data 64'hFEDC_BA98_7654_3210. Expected:
  - First valid in cycle 2: `o_header = 2'b01`, `o_data = 32'h7654_3210`.
  - Next cycle: `o_data = 32'hFEDC_BA98`, `o_frame_word = 1`.
  - Pattern of 32 valid then 1 invalid, repeated over 100 cycles.
- **Misalignment by 5 bits:** issue 5 slips spaced `SLIP_HOLDOFF + 1` apart. After the last slip, every HDR word has `o_header = 2'b01` or 2'b10 and data matches the transmitted data; 61 slips from the same offset also reach lock.
- **Slip during busy:** `i_slip` held high for 10 cycles with `SLIP_HOLDOFF = 4` → exactly 2 slips accepted (cycles 0 and 5); the bit offset shifts by 2.
- **Reset mid-frame:** assert `i_reset_n = 0` immediately after an HDR word → all outputs read 0 in the same cycle; after release, the first valid again occurs in cycle 2.
- **Header check (`RX_GEARBOX_HDR_CHECK_EN` defined):** inject headers 2'b00 and 2'b11 → `o_header_err = 1` on those HDR words only. With the macro undefined → `o_header_err` stays 0.
- **Random stream:** random headers and data with random spaced slips, checked against a bit-serial reference model → zero mismatches over 10k cycles, and fill never exceeds 65.
